// File: rtl/instr_fetch_stage.sv
// ClassMIPS fetch stage. Keeps the PC and runs a single-outstanding imem handshake.
// Fills the IF/ID register, using a one-entry skid for stalls and flush-and-discard on redirects.
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus4,
  output logic [5:0]  opcode,
  output logic [5:0]  funct
);

  typedef enum logic [1:0] {REQ, WAIT, HOLD} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_pend_pc, w_pend_pc_nxt;
  logic        r_discard, w_discard_nxt;
  logic [31:0] r_sk_instr, w_sk_instr_nxt;
  logic [31:0] r_sk_pc4, w_sk_pc4_nxt;
  logic        r_id_valid, w_id_valid_nxt;
  logic [31:0] r_id_instr, w_id_instr_nxt;
  logic [31:0] r_id_pc4, w_id_pc4_nxt;
  logic [31:0] w_pend_pc4;
  logic [31:0] w_target;

  assign w_pend_pc4 = r_pend_pc + 32'd4;
  assign w_target   = branch_target & ~32'h0000_0003;

  assign imem_req    = (r_state == REQ) && !reset;
  assign imem_addr   = r_pc;
  assign id_valid    = r_id_valid;
  assign id_instr    = r_id_instr;
  assign id_pc_plus4 = r_id_pc4;
  assign opcode      = r_id_instr[31:26];
  assign funct       = r_id_instr[5:0];

  always_ff @(posedge clk) begin
    if (reset) r_state <= REQ;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_pend_pc_nxt  = r_pend_pc;
    w_discard_nxt  = r_discard;
    w_sk_instr_nxt = r_sk_instr;
    w_sk_pc4_nxt   = r_sk_pc4;
    // An unstalled IF/ID entry is consumed this cycle unless something reloads it below.
    w_id_valid_nxt = r_id_valid && stall;
    w_id_instr_nxt = r_id_instr;
    w_id_pc4_nxt   = r_id_pc4;

    if (branch_taken) begin
      w_pc_nxt       = w_target;
      w_id_valid_nxt = 1'b0;
      w_sk_instr_nxt = 32'd0;
      w_sk_pc4_nxt   = 32'd0;
      case (r_state)
        WAIT: begin
          if (imem_rvalid) begin
            w_state_nxt   = REQ;
            w_discard_nxt = 1'b0;
          end else begin
            w_discard_nxt = 1'b1;
          end
        end
        REQ: begin
          if (imem_ready) begin
            // The old-PC request was still accepted; its word must be thrown away.
            w_pend_pc_nxt = r_pc;
            w_state_nxt   = WAIT;
            w_discard_nxt = 1'b1;
          end
        end
        default: w_state_nxt = REQ;
      endcase
    end else begin
      case (r_state)
        REQ: begin
          if (imem_ready) begin
            w_pend_pc_nxt = r_pc;
            w_state_nxt   = WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            w_state_nxt = REQ;
            if (r_discard) begin
              w_discard_nxt = 1'b0;
            end else if (!r_id_valid || !stall) begin
              w_id_valid_nxt = 1'b1;
              w_id_instr_nxt = imem_rdata;
              w_id_pc4_nxt   = w_pend_pc4;
              w_pc_nxt       = w_pend_pc4;
            end else begin
              w_sk_instr_nxt = imem_rdata;
              w_sk_pc4_nxt   = w_pend_pc4;
              w_pc_nxt       = w_pend_pc4;
              w_state_nxt    = HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            w_id_valid_nxt = 1'b1;
            w_id_instr_nxt = r_sk_instr;
            w_id_pc4_nxt   = r_sk_pc4;
            w_state_nxt    = REQ;
          end
        end
        default: w_state_nxt = REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_pend_pc  <= 32'd0;
      r_discard  <= 1'b0;
      r_sk_instr <= 32'd0;
      r_sk_pc4   <= 32'd0;
      r_id_valid <= 1'b0;
      r_id_instr <= 32'd0;
      r_id_pc4   <= 32'd0;
    end else begin
      r_pc       <= w_pc_nxt;
      r_pend_pc  <= w_pend_pc_nxt;
      r_discard  <= w_discard_nxt;
      r_sk_instr <= w_sk_instr_nxt;
      r_sk_pc4   <= w_sk_pc4_nxt;
      r_id_valid <= w_id_valid_nxt;
      r_id_instr <= w_id_instr_nxt;
      r_id_pc4   <= w_id_pc4_nxt;
    end
  end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: scripted memory model, address and IF/ID scoreboards
// drained by a negedge monitor, and directed phases with hand-computed expectations.
module tb_instr_fetch_stage;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } id_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc_plus4;
  logic [5:0]  opcode;
  logic [5:0]  funct;

  int tests = 0;
  int fails = 0;
  int budget = 0;
  int mem_lat = 1;
  int mem_cnt = 0;
  int acc_cnt = 0;
  int cyc = 0;
  int prev_cons = -1;
  bit rate_chk = 1'b0;
  logic [31:0] mem_addr = 32'd0;
  logic [31:0] exp_addr[$];
  id_t         exp_id[$];

  instr_fetch_stage dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc_plus4(id_pc_plus4),
    .opcode(opcode), .funct(funct)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a == 32'd0) ? 32'h0000_0020 : (a ^ 32'hA000_0000);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_id(input logic [31:0] instr, input logic [31:0] pc4);
    id_t e;
    e.instr = instr;
    e.pc4   = pc4;
    exp_id.push_back(e);
  endtask

  task automatic wait_drain(input string nm);
    for (int i = 0; i < 60; i++) begin
      if (exp_id.size() == 0 && exp_addr.size() == 0) break;
      tick();
    end
    chk({nm, "_drain_id"}, 32'(exp_id.size()), 32'd0);
    chk({nm, "_drain_addr"}, 32'(exp_addr.size()), 32'd0);
  endtask

  // Memory: after acceptance, responds mem_lat cycles later; ready follows the fetch budget.
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
    imem_ready  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      imem_rvalid = 1'b0;
      if (mem_cnt > 0) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = memword(mem_addr);
        end
      end
      imem_ready = (budget > 0);
    end
  end

  // Monitor: sees acceptances and IF/ID consumptions one half-cycle before the edge.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (imem_req && imem_ready) begin
      mem_addr = imem_addr;
      mem_cnt  = mem_lat;
      budget--;
      acc_cnt++;
      if (exp_addr.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_fetch: got addr %08h expected none", imem_addr);
      end else begin
        chk("imem_addr", imem_addr, exp_addr.pop_front());
      end
    end
    if (!reset && id_valid && !stall && !branch_taken) begin
      if (exp_id.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_id: got instr %08h pc4 %08h expected none", id_instr, id_pc_plus4);
      end else begin
        id_t e;
        e = exp_id.pop_front();
        tests++;
        if (id_instr !== e.instr || id_pc_plus4 !== e.pc4 ||
            opcode !== e.instr[31:26] || funct !== e.instr[5:0]) begin
          fails++;
          $display("FAIL id_out: got instr %08h pc4 %08h op %02h fn %02h expected instr %08h pc4 %08h",
                   id_instr, id_pc_plus4, opcode, funct, e.instr, e.pc4);
        end
      end
      if (rate_chk && prev_cons >= 0) chk("id_rate", 32'(cyc - prev_cons), 32'd2);
      prev_cons = cyc;
    end
  end

  initial begin
    bit found;
    int base;
    reset = 1'b1;
    stall = 1'b0;
    branch_taken = 1'b0;
    branch_target = 32'd0;
    repeat (3) tick();
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_id_instr", id_instr, 32'd0);
    chk("rst_id_pc4", id_pc_plus4, 32'd0);
    chk("rst_imem_addr", imem_addr, 32'd0);

    // Streaming from reset, zero wait states.
    foreach (exp_addr[i]) exp_addr.delete(i);
    exp_addr.push_back(32'h0);  exp_addr.push_back(32'h4);
    exp_addr.push_back(32'h8);  exp_addr.push_back(32'hC);
    push_id(32'h0000_0020, 32'h4);
    push_id(32'hA000_0004, 32'h8);
    push_id(32'hA000_0008, 32'hC);
    push_id(32'hA000_000C, 32'h10);
    budget = 4;
    rate_chk = 1'b1;
    tick();
    reset = 1'b0;
    wait_drain("stream");
    rate_chk = 1'b0;

    // Stall: first word in IF/ID, second in skid, released in order.
    exp_addr.push_back(32'h10); exp_addr.push_back(32'h14);
    push_id(32'hA000_0010, 32'h14);
    push_id(32'hA000_0014, 32'h18);
    stall = 1'b1;
    budget = 2;
    repeat (9) tick();
    chk("stall_no_req", 32'(imem_req), 32'd0);
    chk("stall_id_valid", 32'(id_valid), 32'd1);
    chk("stall_id_instr", id_instr, 32'hA000_0010);
    chk("stall_id_pc4", id_pc_plus4, 32'h14);
    stall = 1'b0;
    wait_drain("stall");

    // Redirect in WAIT: held IF/ID is flushed, in-flight word discarded.
    exp_addr.push_back(32'h18); exp_addr.push_back(32'h1C); exp_addr.push_back(32'h100);
    push_id(32'hA000_0100, 32'h104);
    stall = 1'b1;
    mem_lat = 3;
    base = acc_cnt;
    budget = 2;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (acc_cnt == base + 2 && mem_cnt == 2) begin found = 1'b1; break; end
    end
    chk("br_reach_wait", 32'(found), 32'd1);
    chk("br_pre_valid", 32'(id_valid), 32'd1);
    branch_taken = 1'b1;
    branch_target = 32'h0000_0103;
    tick();
    branch_taken = 1'b0;
    stall = 1'b0;
    mem_lat = 1;
    chk("br_flush_valid", 32'(id_valid), 32'd0);
    budget = 1;
    wait_drain("branch");

    // Ready held low: request stable; then PC wraps through zero.
    branch_taken = 1'b1;
    branch_target = 32'hFFFF_FFFF;
    tick();
    branch_taken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("nordy_req", 32'(imem_req), 32'd1);
      chk("nordy_addr", imem_addr, 32'hFFFF_FFFC);
      tick();
    end
    exp_addr.push_back(32'hFFFF_FFFC); exp_addr.push_back(32'h0);
    push_id(32'h5FFF_FFFC, 32'h0);
    push_id(32'h0000_0020, 32'h4);
    budget = 2;
    wait_drain("wrap");

    // Reset during WAIT; response lands afterwards and must be ignored.
    exp_addr.push_back(32'h4);
    mem_lat = 2;
    base = acc_cnt;
    budget = 1;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (acc_cnt == base + 1 && mem_cnt == 1) begin found = 1'b1; break; end
    end
    chk("rstw_reach_wait", 32'(found), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("rstw_id_valid", 32'(id_valid), 32'd0);
    chk("rstw_imem_addr", imem_addr, 32'h0);
    chk("rstw_imem_req", 32'(imem_req), 32'd1);
    tick();
    chk("rstw_id_valid2", 32'(id_valid), 32'd0);
    mem_lat = 1;
    exp_addr.push_back(32'h0);
    push_id(32'h0000_0020, 32'h4);
    budget = 1;
    wait_drain("rst_restart");
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_fetch_stage.md
# instr_fetch_stage

Fetch stage of the ClassMIPS core, directly upstream of the control unit and register file. It holds the program counter, issues word fetches to instruction memory over a request/response handshake with at most one request outstanding, and captures each returned word in an IF/ID register. That register exposes `opcode`/`funct` to the control unit and `pc_plus4` to the datapath. It also handles downstream stalls through a one-entry skid buffer, and branch redirects by flushing and discarding in-flight fetches.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; bits [1:0] must be 0.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `imem_req` output 1: fetch request, valid in state REQ only.
- `imem_addr` output 32: byte address of the fetch (= `pc`), bits [1:0] always 0.
- `imem_ready` input 1: request accepted when `imem_req && imem_ready`.
- `imem_rvalid` input 1: response valid; arrives ≥1 cycle after acceptance.
- `imem_rdata` input 32: instruction word, sampled when `imem_rvalid`.
- `stall` input 1: downstream cannot consume IF/ID this cycle.
- `branch_taken` input 1: redirect fetch to `branch_target`.
- `branch_target` input 32: new PC; bits [1:0] forced to 0.
- `id_valid` output 1: IF/ID holds a valid instruction.
- `id_instr` output 32: IF/ID instruction.
- `id_pc_plus4` output 32: fetch address of `id_instr` + 4.
- `opcode` output 6: `id_instr[31:26]`, combinational.
- `funct` output 6: `id_instr[5:0]`, combinational.

## Operation
**State and reset**
- FSM states: REQ, WAIT, HOLD.
- Registers: `pc`, `pend_pc`, `discard`, skid (`sk_instr`, `sk_pc4`), IF/ID (`id_valid`, `id_instr`, `id_pc_plus4`).
- Reset values: state=REQ, `pc`=`RESET_PC`, `discard`=0, `id_valid`=0, `id_instr`=0, `id_pc_plus4`=0, skid=0.
- `imem_req`=0 while `reset` is high.

**Consume rule**
- IF/ID is consumed each cycle `id_valid && !stall`; `id_valid` drops unless it is reloaded in the same cycle.

**State transitions**
- REQ: `imem_req`=1.
  - On `imem_ready`: `pend_pc`<=`pc`, go to WAIT.
  - `imem_rvalid` in REQ is ignored.
- WAIT: `imem_req`=0.
  - On `imem_rvalid` with `discard`=1: drop the word, clear `discard`, go to REQ.
  - On `imem_rvalid` with `discard`=0 and IF/ID free or being consumed (`!id_valid || !stall`): load IF/ID with `imem_rdata` and `pend_pc+4`, set `id_valid`=1, `pc`<=`pend_pc+4`, go to REQ.
  - On `imem_rvalid` with `discard`=0 and `id_valid && stall`: write the word and `pend_pc+4` into the skid, `pc`<=`pend_pc+4`, go to HOLD.
- HOLD: `imem_req`=0.
  - When `!stall`: move skid into IF/ID (`id_valid`=1), go to REQ.

**Branch redirect** (highest priority, overrides `stall` and all of the above in that cycle)
- `pc`<=`{branch_target[31:2],2'b00}`, `id_valid`<=0, skid cleared.
- From WAIT: stay in WAIT with `discard`<=1; if `imem_rvalid` arrives in the same cycle, that word is dropped and the FSM goes to REQ with `discard`=0.
- From REQ with `imem_ready`=1 in the same cycle: the old-PC request is accepted; go to WAIT with `discard`<=1.
- From REQ otherwise, or from HOLD: go to REQ.

**Arithmetic**
- 32-bit unsigned PC; +4 wraps modulo 2^32 (32'hFFFF_FFFC → 32'h0000_0000).

## Timing
- Best-case latency: acceptance at cycle N, `imem_rvalid` at N+1, `id_valid` high at N+2; the next `imem_req` is asserted at N+2.
- Sustained throughput: one instruction per 2 cycles when memory has zero wait states.
- `id_*` outputs are registered; `opcode`, `funct`, `imem_req`, and `imem_addr` are combinational from registers.
- `imem_addr` is stable while `imem_req` is high and `imem_ready` is low.
- Sequence order is preserved: no instruction is lost or duplicated across a stall; every instruction fetched before a redirect is never presented after it.
- A `reset` asserted in any state returns all registers to their reset values on the next edge; a response still in flight after reset is ignored (state REQ).

## Test plan
- Reset release, `RESET_PC`=0, memory always ready with 1-cycle response, no stall -> `imem_addr` sequence 0,4,8,…; `id_pc_plus4` sequence 4,8,12,…; `id_valid` high every other cycle.
- Word 32'h0000_0020 (add) fetched -> `opcode`=6'h00, `funct`=6'h20.
- `stall` held 5 cycles while a second response arrives -> first word held in IF/ID, second in skid, no new `imem_req`; on release both appear in order, no loss or duplication.
- `branch_taken` with `branch_target`=32'h0000_0103 while in WAIT -> outstanding word dropped, `id_valid`=0, next `imem_addr`=32'h0000_0100.
- `imem_ready` low 3 cycles -> `imem_req`/`imem_addr` held stable; `pc` wraps from 32'hFFFF_FFFC to 32'h0000_0000.
- `reset` asserted mid-WAIT, with `imem_rvalid` arriving the following cycle -> word ignored, `id_valid`=0, `imem_addr`=`RESET_PC`.
